iter_multiplier: RTL and testbench
==================================

Name: iter_multiplier

Overview:
- Multi-cycle 64x64 integer multiplier for MUL, UMULH and SMULH.
- Sits between the register file read ports and its write port.
- Operands come from BusA/BusB. The registered result, destination register and write strobe drive BusW/RW/RegWr through the writeback mux.
- Uses a radix-2 shift-add datapath: one multiplier bit per clock.

Parameters:
WIDTH, 64, operand and result width in bits
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous active-high reset
Start  input  1  request; sampled only in IDLE or DONE
Op  input  2  00=MUL (low half), 01=UMULH, 10=SMULH, 11=MUL
OpA  input  WIDTH  multiplicand (from BusA)
OpB  input  WIDTH  multiplier (from BusB)
DestIn  input  5  destination register number
Busy  output  1  high in RUN or FIX
Done  output  1  one-cycle completion pulse
Result  output  WIDTH  registered result; held until the next Done
DestOut  output  5  captured DestIn; held with Result
RegWrOut  output  1  equals Done; write strobe to the register file

Behaviour:
- Clocking: one clock, Clk. Reset is asynchronous and active-high.
- Reset, asserted at any time including mid-operation: state=IDLE; Busy=0, Done=0, RegWrOut=0, Result=0, DestOut=0; counter and accumulator cleared. Any in-flight operation is abandoned and produces no Done.
- IDLE:
  - Start=1 at an edge captures Op, DestIn, OpA and OpB.
  - SMULH captures magnitudes (|x| by two's-complement negation when the MSB is set; 0x8000..0 maps to unsigned 2^63). It also records neg = MSB(OpA) XOR MSB(OpB).
  - Clears the 2*WIDTH product register and counter; next state RUN.
- RUN, WIDTH cycles:
  - Each edge: if multiplier LSB=1, add the multiplicand to the upper half of the product.
  - Then shift the (WIDTH+1)-bit sum:upper:lower right by 1, keeping the carry.
  - Counter increments; after iteration WIDTH-1, next state FIX.
- FIX, one cycle:
  - If SMULH and neg, take the two's-complement negation of the full 128-bit product.
  - Select the low half for MUL/11, the high half otherwise.
  - Register Result and DestOut; assert Done; next state DONE.
- DONE, one cycle: Done=RegWrOut=1.
  - If Start=1 at this edge, accept a new operation exactly as from IDLE (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Latency: Start sampled at edge E0 → Done high during the cycle after edge E0+WIDTH+1 (66 cycles at default). Throughput is one operation per WIDTH+2 cycles.
- Start while Busy=1 is ignored; operands and outputs are unaffected.
- Result and DestOut change only on the FIX→DONE edge or reset.
- DestIn=31 is passed through unchanged; Done still pulses. XZR discard is the register file's responsibility.
- Result widths: all arithmetic is mod 2^128 in the product register. No overflow flag.

Test Plan:
1. Reset asserted mid-RUN (30 cycles after Start) → all outputs 0 asynchronously; no Done ever follows; next Start (Op=00, 7*6) gives Result=0x2A.
2. Op=00, OpA=3, OpB=5, DestIn=4 → Done pulses exactly one cycle, 66 cycles after the Start edge; Result=0xF, DestOut=4, RegWrOut=1 for that cycle; Busy=1 for the preceding 65 cycles.
3. Op=01, OpA=OpB=0xFFFFFFFFFFFFFFFF → Result=0xFFFFFFFFFFFFFFFE. Same operands with Op=00 → Result=0x0000000000000001.
4. Op=10 cases:
   - OpA=-2, OpB=3 → Result=0xFFFFFFFFFFFFFFFF.
   - OpA=OpB=-1 → Result=0x0.
   - OpA=OpB=0x8000000000000000 → Result=0x4000000000000000.
5. Start held high for the whole first operation: the first operation is unaffected and the second Start is taken only on the DONE edge; the second Done follows 66 cycles later with the new operands' result. Result holds the first value in between.
6. Randomised 200 operations (random Op/operands/DestIn, random idle gaps) checked against a 128-bit reference model; each Done is checked for exactly one cycle high and correct DestOut.

Source files
------------

// File: rtl/iter_multiplier.sv
// rtl/iter_multiplier.sv - radix-2 shift-add 64x64 multiplier for MUL, UMULH and SMULH.
// One multiplier bit per clock; signed high half via magnitudes plus a final negate.
module iter_multiplier #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [4:0]       DestIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       DestOut,
  output logic             RegWrOut
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [4:0]           dest_q, dest_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [4:0]           dest_out_q, dest_out_d;

  logic                 is_smulh_in;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_fix;
  logic                 take_high;

  // SMULH works on magnitudes; 0x80..0 negates to itself, which reads as 2^(WIDTH-1) unsigned.
  assign is_smulh_in = (Op == 2'b10);
  assign abs_a       = (is_smulh_in && OpA[WIDTH-1]) ? -OpA : OpA;
  assign abs_b       = (is_smulh_in && OpB[WIDTH-1]) ? -OpB : OpB;

  // The multiplier sits in the low half of the product and shifts out as the sum shifts in.
  assign sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_fix  = neg_q ? -prod_q : prod_q;
  assign take_high = (op_q == 2'b01) || (op_q == 2'b10);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      neg_q      <= 1'b0;
      dest_q     <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      dest_out_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      dest_q     <= dest_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      dest_out_q <= dest_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_d      = neg_q;
    dest_d     = dest_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    dest_out_d = dest_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          op_d    = Op;
          dest_d  = DestIn;
          neg_d   = is_smulh_in && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
          mcand_d = abs_a;
          prod_d  = {{WIDTH{1'b0}}, abs_b};
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d   = take_high ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
        dest_out_d = dest_q;
        state_d    = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign Done     = (state_q == S_DONE);
  assign RegWrOut = Done;
  assign Result   = result_q;
  assign DestOut  = dest_out_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// tb/tb_iter_multiplier.sv - self-checking bench for iter_multiplier.
module tb_iter_multiplier;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [63:0] OpA = '0;
  logic [63:0] OpB = '0;
  logic [4:0]  DestIn = '0;
  logic        Busy, Done, RegWrOut;
  logic [63:0] Result;
  logic [4:0]  DestOut;

  int n_checks = 0;
  int n_fail = 0;

  iter_multiplier dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .DestIn(DestIn), .Busy(Busy), .Done(Done), .Result(Result),
    .DestOut(DestOut), .RegWrOut(RegWrOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  dest;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] u, s;
    u = {64'd0, a} * {64'd0, b};
    s = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    case (op)
      2'b01:   return u[127:64];
      2'b10:   return s[127:64];
      default: return u[63:0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one operation and follows it to its Done pulse.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] d, output logic [63:0] res, output logic [4:0] dout,
                        output logic regwr, output int lat, output int busy_cnt,
                        output logic one_cycle);
    @(negedge Clk);
    Start = 1'b1; Op = op; OpA = a; OpB = b; DestIn = d;
    @(posedge Clk);
    #1 Start = 1'b0;
    lat = -1; busy_cnt = 0; res = '0; dout = '0; regwr = 1'b0; one_cycle = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge Clk);
      if (Done) begin
        lat = i; res = Result; dout = DestOut; regwr = RegWrOut;
        break;
      end
      if (Busy) busy_cnt++;
    end
    @(negedge Clk);
    one_cycle = (lat > 0) && !Done;
  endtask

  vec_t        vecs[$];
  logic [63:0] res, r2a, r2b, exp2;
  logic [4:0]  dout;
  logic        regwr, one;
  int          lat, bcnt, seen, held_bad;

  initial begin
    vecs.push_back('{2'b00, 64'd3, 64'd5, 5'd4, 64'hF});
    vecs.push_back('{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'h1});
    vecs.push_back('{2'b10, -64'sd2, 64'd3, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'h0});
    vecs.push_back('{2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6, 64'h4000_0000_0000_0000});
    vecs.push_back('{2'b11, 64'd7, 64'd6, 5'd31, 64'h2A});
    vecs.push_back('{2'b01, 64'h1_0000_0000, 64'h1_0000_0000, 5'd9, 64'h1});

    repeat (2) @(negedge Clk);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_regwr", 64'(RegWrOut), 64'd0);
    chk("reset_result", Result, 64'd0);
    chk("reset_dest", 64'(DestOut), 64'd0);
    Reset = 1'b0;

    foreach (vecs[k]) begin
      run_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].dest, res, dout, regwr, lat, bcnt, one);
      chk($sformatf("vec%0d_result", k), res, vecs[k].exp);
      chk($sformatf("vec%0d_dest", k), 64'(dout), 64'(vecs[k].dest));
      chk($sformatf("vec%0d_latency", k), 64'(lat), 64'd66);
      chk($sformatf("vec%0d_busy_cycles", k), 64'(bcnt), 64'd65);
      chk($sformatf("vec%0d_regwr", k), 64'(regwr), 64'd1);
      chk($sformatf("vec%0d_one_cycle", k), 64'(one), 64'd1);
    end

    // Reset mid-run: outputs clear without a clock edge and the operation never completes.
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; OpA = 64'd5; OpB = 64'd9; DestIn = 5'd12;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (30) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_done", 64'(Done), 64'd0);
    chk("midrst_regwr", 64'(RegWrOut), 64'd0);
    chk("midrst_result", Result, 64'd0);
    chk("midrst_dest", 64'(DestOut), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge Clk);
      if (Done) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    run_op(2'b00, 64'd7, 64'd6, 5'd8, res, dout, regwr, lat, bcnt, one);
    chk("after_rst_result", res, 64'h2A);
    chk("after_rst_latency", 64'(lat), 64'd66);

    // Start held high throughout: second op is taken only on the DONE edge.
    r2a = {$urandom, $urandom};
    r2b = {$urandom, $urandom};
    exp2 = ref_mul(2'b01, r2a, r2b);
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; OpA = 64'd11; OpB = 64'd13; DestIn = 5'd7;
    @(posedge Clk);
    #1 Op = 2'b01; OpA = r2a; OpB = r2b; DestIn = 5'd9;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge Clk);
      if (Done) begin lat = i; break; end
    end
    chk("held_first_latency", 64'(lat), 64'd66);
    chk("held_first_result", Result, 64'd143);
    chk("held_first_dest", 64'(DestOut), 64'd7);
    @(posedge Clk);
    #1 Start = 1'b0;
    lat = -1; held_bad = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge Clk);
      if (Done) begin lat = i; break; end
      if (Result !== 64'd143) held_bad++;
    end
    chk("held_second_latency", 64'(lat), 64'd66);
    chk("held_result_hold", 64'(held_bad), 64'd0);
    chk("held_second_result", Result, exp2);
    chk("held_second_dest", 64'(DestOut), 64'd9);
    @(negedge Clk);

    // Randomised operations against the arithmetic reference.
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  op;
      logic [63:0] a, b;
      logic [4:0]  d;
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      d  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = 64'h8000_0000_0000_0000;
      if ($urandom_range(0, 7) == 0) b = '1;
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      run_op(op, a, b, d, res, dout, regwr, lat, bcnt, one);
      chk($sformatf("rnd%0d_result op=%0d a=%h b=%h", n, op, a, b), res, ref_mul(op, a, b));
      chk($sformatf("rnd%0d_dest", n), 64'(dout), 64'(d));
      chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'd66);
      chk($sformatf("rnd%0d_one_cycle", n), 64'(one), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
